// File: rtl/fios_mem_pkg.sv
// Shared types and address map for the FIOS memory-side controller.
package fios_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdDrain,
        StWr,
        StDone,
        StRelease
    } mem_state_e;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_M = 2'd2;

    // A sits at base 0; the others follow back to back.
    function automatic int unsigned base_b(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned base_m(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned base_res(input int unsigned n);
        return 3 * n;
    endfunction

endpackage

// File: rtl/fios_rd_delay.sv
// RD_LAT-deep shift register that tags each issued BRAM read with its operand
// select and word index so they line up with the returning read data.
module fios_rd_delay #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned IDX_W  = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [1:0]       sel_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [1:0]       sel_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             pending_o
);

    logic             vld_q [RD_LAT];
    logic [1:0]       sel_q [RD_LAT];
    logic [IDX_W-1:0] idx_q [RD_LAT];

    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                vld_q[i] <= 1'b0;
                sel_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            sel_q[0] <= sel_i;
            idx_q[0] <= idx_i;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                sel_q[i] <= sel_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[RD_LAT-1];
    assign sel_o   = sel_q[RD_LAT-1];
    assign idx_o   = idx_q[RD_LAT-1];

    // Reads still in flight behind the head; the line empties next cycle when clear.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i + 1 < int'(RD_LAT); i++) begin
            pending_o = pending_o | vld_q[i];
        end
    end

endmodule

// File: rtl/fios_mem_ctrl.sv
// FIOS memory-side responder: loads A/B/M from BRAM into the core, stores results back.
// Optional mid-transfer abort on a dropped request is enabled by FIOS_MEM_ABORT_EN.
module fios_mem_ctrl
    import fios_mem_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 8,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         mem_start_i,
    input  logic                         load_store_i,
    output logic                         load_done_o,
    output logic                         store_done_o,
    output logic                         bram_en_o,
    output logic                         bram_we_o,
    output logic [ADDR_W-1:0]            bram_addr_o,
    output logic [WORD_W-1:0]            bram_wdata_o,
    input  logic [WORD_W-1:0]            bram_rdata_i,
    output logic                         op_valid_o,
    output logic [1:0]                   op_sel_o,
    output logic [$clog2(NUM_WORDS)-1:0] op_idx_o,
    output logic [WORD_W-1:0]            op_data_o,
    output logic [$clog2(NUM_WORDS)-1:0] res_addr_o,
    input  logic [WORD_W-1:0]            res_data_i
`ifdef FIOS_MEM_ABORT_EN
    ,
    output logic                         abort_o
`endif
);

    localparam int unsigned       IDX_W   = $clog2(NUM_WORDS);
    localparam logic [ADDR_W-1:0] RdLast  = ADDR_W'(base_res(NUM_WORDS) - 1);
    localparam logic [ADDR_W-1:0] WrBase  = ADDR_W'(base_res(NUM_WORDS));
    localparam logic [ADDR_W-1:0] WrLast  = ADDR_W'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] ResLast = ADDR_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]  IdxLast = IDX_W'(NUM_WORDS - 1);

    mem_state_e        state_q;
    logic              is_store_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [1:0]        sel_q;
    logic [IDX_W-1:0]  idx_q;

    logic              abort_req;
    logic              rd_pending;
    logic              head_valid;
    logic [1:0]        head_sel;
    logic [IDX_W-1:0]  head_idx;

`ifdef FIOS_MEM_ABORT_EN
    assign abort_req = !mem_start_i && (state_q inside {StRdIssue, StRdDrain, StWr});
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            is_store_q   <= 1'b0;
            cnt_q        <= '0;
            sel_q        <= OP_A;
            idx_q        <= '0;
            load_done_o  <= 1'b0;
            store_done_o <= 1'b0;
            bram_en_o    <= 1'b0;
            bram_we_o    <= 1'b0;
            bram_addr_o  <= '0;
            res_addr_o   <= '0;
`ifdef FIOS_MEM_ABORT_EN
            abort_o      <= 1'b0;
`endif
        end else if (abort_req) begin
            state_q     <= StIdle;
            bram_en_o   <= 1'b0;
            bram_we_o   <= 1'b0;
            bram_addr_o <= '0;
            res_addr_o  <= '0;
`ifdef FIOS_MEM_ABORT_EN
            abort_o     <= 1'b1;
`endif
        end else begin
            load_done_o  <= 1'b0;
            store_done_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mem_start_i) begin
                        is_store_q <= load_store_i;
                        cnt_q      <= '0;
                        sel_q      <= OP_A;
                        idx_q      <= '0;
                        res_addr_o <= '0;
                        if (load_store_i) begin
                            state_q <= StWr;
                        end else begin
                            state_q     <= StRdIssue;
                            bram_en_o   <= 1'b1;
                            bram_we_o   <= 1'b0;
                            bram_addr_o <= '0;
                        end
                    end
                end
                StRdIssue: begin
                    if (cnt_q == RdLast) begin
                        state_q     <= StRdDrain;
                        bram_en_o   <= 1'b0;
                        bram_addr_o <= '0;
                    end else begin
                        cnt_q       <= cnt_q + ADDR_W'(1);
                        bram_addr_o <= cnt_q + ADDR_W'(1);
                        if (idx_q == IdxLast) begin
                            idx_q <= '0;
                            sel_q <= sel_q + 2'd1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                StRdDrain: begin
                    if (!rd_pending) begin
                        state_q      <= StDone;
                        load_done_o  <= !is_store_q;
                        store_done_o <= is_store_q;
                    end
                end
                StWr: begin
                    // Result word cnt_q-1 is on res_data_i while its write is on the port.
                    if (cnt_q == WrLast) begin
                        state_q      <= StDone;
                        bram_en_o    <= 1'b0;
                        bram_we_o    <= 1'b0;
                        bram_addr_o  <= '0;
                        load_done_o  <= !is_store_q;
                        store_done_o <= is_store_q;
                    end else begin
                        cnt_q       <= cnt_q + ADDR_W'(1);
                        res_addr_o  <= (cnt_q < ResLast) ? IDX_W'(cnt_q + ADDR_W'(1)) : '0;
                        bram_en_o   <= 1'b1;
                        bram_we_o   <= 1'b1;
                        bram_addr_o <= WrBase + cnt_q;
                    end
                end
                StDone: begin
                    state_q <= StRelease;
                end
                StRelease: begin
                    if (!mem_start_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fios_rd_delay #(
        .RD_LAT (RD_LAT),
        .IDX_W  (IDX_W)
    ) u_rd_delay (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .flush_i   (abort_req),
        .valid_i   (bram_en_o & ~bram_we_o),
        .sel_i     (sel_q),
        .idx_i     (idx_q),
        .valid_o   (head_valid),
        .sel_o     (head_sel),
        .idx_o     (head_idx),
        .pending_o (rd_pending)
    );

    assign op_valid_o   = head_valid;
    assign op_sel_o     = head_valid ? head_sel : '0;
    assign op_idx_o     = head_valid ? head_idx : '0;
    assign op_data_o    = head_valid ? bram_rdata_i : '0;
    assign bram_wdata_o = bram_we_o ? res_data_i : '0;

endmodule

// File: tb/tb_fios_mem_ctrl.sv
// Scoreboard bench for fios_mem_ctrl (N=4, RD_LAT=2) with BRAM and result-file models.
module tb_fios_mem_ctrl;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int RL = 2;
    localparam int IW = $clog2(N);

    typedef struct {
        int          cyc;
        int          a;
        int          b;
        logic [31:0] d;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          mem_start = 1'b0;
    logic          load_store = 1'b0;
    logic          load_done, store_done;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_wdata;
    logic [W-1:0]  bram_rdata;
    logic          op_valid;
    logic [1:0]    op_sel;
    logic [IW-1:0] op_idx;
    logic [W-1:0]  op_data;
    logic [IW-1:0] res_addr;
    logic [W-1:0]  res_data;
`ifdef FIOS_MEM_ABORT_EN
    logic          abort;
`endif

    logic [W-1:0] mem [0:(1<<AW)-1];
    logic [W-1:0] res_file [0:N-1];
    logic [W-1:0] rd_p1;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    ev_t rd_q[$];
    ev_t op_q[$];
    ev_t wr_q[$];
    ev_t done_q[$];

    fios_mem_ctrl #(
        .WORD_W    (W),
        .NUM_WORDS (N),
        .ADDR_W    (AW),
        .RD_LAT    (RL)
    ) dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .mem_start_i  (mem_start),
        .load_store_i (load_store),
        .load_done_o  (load_done),
        .store_done_o (store_done),
        .bram_en_o    (bram_en),
        .bram_we_o    (bram_we),
        .bram_addr_o  (bram_addr),
        .bram_wdata_o (bram_wdata),
        .bram_rdata_i (bram_rdata),
        .op_valid_o   (op_valid),
        .op_sel_o     (op_sel),
        .op_idx_o     (op_idx),
        .op_data_o    (op_data),
        .res_addr_o   (res_addr),
        .res_data_i   (res_data)
`ifdef FIOS_MEM_ABORT_EN
        ,
        .abort_o      (abort)
`endif
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM read pipe and one-cycle result register file.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_en === 1'b1 && bram_we === 1'b0) rd_p1 <= mem[bram_addr];
        bram_rdata <= rd_p1;
        res_data   <= res_file[res_addr];
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (op_valid === 1'b1) begin
            if (op_q.size() == 0) chk("op_unexpected", 1, 0);
            else begin
                e = op_q.pop_front();
                chk("op_cycle", cyc, e.cyc);
                chk("op_sel", op_sel, e.a);
                chk("op_idx", op_idx, e.b);
                chk("op_data", op_data, e.d);
            end
        end
        if (bram_en === 1'b1 && bram_we === 1'b0) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = rd_q.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_addr", bram_addr, e.a);
            end
        end
        if (bram_en === 1'b1 && bram_we === 1'b1) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                e = wr_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", bram_addr, e.a);
                chk("wr_data", bram_wdata, e.d);
            end
        end
        if (bram_en === 1'b0 && bram_we !== 1'b0) chk("we_without_en", bram_we, 0);
        if (load_done === 1'b1 || store_done === 1'b1) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                e = done_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_kind", {load_done, store_done}, e.a == 1 ? 2'b01 : 2'b10);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, {bram_en, bram_we, bram_addr, op_valid, op_sel, op_idx, res_addr,
                             load_done, store_done}, 0);
        chk({name, "_data"}, {bram_wdata, op_data}, 0);
    endtask

    // st: 0 load / 1 store; rst_at: cycle to assert reset (0 = none);
    // drop_at: cycle to drop the request (0 = none); hold: extra cycles after done.
    task automatic run_op(input bit st, input int rst_at, input int drop_at, input int hold);
        int t0, cut, last, done_c;
        bit aborted;
        ev_t e;
        t0 = cyc;
        done_c = st ? N + 2 : 3 * N + RL + 1;
`ifdef FIOS_MEM_ABORT_EN
        aborted = (drop_at > 0);
`else
        aborted = 1'b0;
`endif
        cut = (rst_at > 0) ? rst_at : (aborted ? drop_at : (1 << 30));
        if (st) begin
            for (int j = 0; j < N; j++) begin
                if (2 + j <= cut) begin
                    e.cyc = t0 + 2 + j; e.a = 3 * N + j; e.b = 0; e.d = res_file[j];
                    wr_q.push_back(e);
                end
            end
        end else begin
            for (int k = 0; k < 3 * N; k++) begin
                if (1 + k <= cut) begin
                    e.cyc = t0 + 1 + k; e.a = k; e.b = 0; e.d = '0;
                    rd_q.push_back(e);
                end
                if (1 + RL + k <= cut) begin
                    e.cyc = t0 + 1 + RL + k; e.a = k / N; e.b = k % N; e.d = mem[k];
                    op_q.push_back(e);
                end
            end
        end
        if (rst_at == 0 && !aborted) begin
            e.cyc = t0 + done_c; e.a = st ? 1 : 0; e.b = 0; e.d = '0;
            done_q.push_back(e);
        end
        last = (cut < (1 << 30)) ? cut : done_c + 1 + hold;
        load_store = st;
        mem_start  = 1'b1;
        while (cyc < t0 + last) begin
            if (drop_at > 0 && cyc == t0 + drop_at) mem_start = 1'b0;
            tick();
        end
        if (rst_at > 0) reset_i = 1'b1;
        mem_start = 1'b0;
        tick();
        reset_i = 1'b0;
        if (rst_at > 0) begin
            @(negedge clk);
            check_zero("reset_mid_load");
        end
`ifdef FIOS_MEM_ABORT_EN
        if (aborted) begin
            @(negedge clk);
            chk("abort_set", abort, 1);
            repeat (4) tick();
            chk("abort_sticky", abort, 1);
            reset_i = 1'b1;
            tick();
            reset_i = 1'b0;
            @(negedge clk);
            chk("abort_cleared", abort, 0);
        end
`endif
        tick();
        tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 3 * N; i++) mem[i] = $urandom;
        for (int j = 0; j < N; j++) res_file[j] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < 3 * N; i++) mem[i] = 32'h100 + i;
        for (int j = 0; j < N; j++) res_file[j] = 32'hA0 + j;
        rd_p1 = '0;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
`ifdef FIOS_MEM_ABORT_EN
        chk("reset_abort", abort, 0);
`endif
        reset_i = 1'b0;
        tick();

        run_op(1'b0, 0, 0, 5);   // load, request held 5 cycles past done
        run_op(1'b1, 0, 0, 0);   // store accepted after the release
        run_op(1'b0, 6, 0, 0);   // reset in cycle 6 of a load
        run_op(1'b0, 0, 0, 0);   // full load after the reset
        run_op(1'b1, 0, 3, 0);   // request dropped in cycle 3 of a store

        for (int it = 0; it < 12; it++) begin
            fill_random();
            run_op(1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 5));
        end

        repeat (6) tick();
        chk("rd_leftover", rd_q.size(), 0);
        chk("op_leftover", op_q.size(), 0);
        chk("wr_leftover", wr_q.size(), 0);
        chk("done_leftover", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
